// File: rtl/imem_loader.sv
// Byte-stream loader that assembles little-endian words into instruction memory while halting the CPU.
// Optional checksum byte after the last word when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int unsigned DEPTH      = 32,
  parameter logic [7:0]  START_BYTE = 8'h4C
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_load_enable,
  output logic [31:0] o_write_reg,
  output logic [31:0] o_write_data,
  output logic        o_cpu_halt,
  output logic        o_load_done,
  output logic        o_error,
  output logic [7:0]  o_word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic        load_enable_d, cpu_halt_d, load_done_d, error_d;
  logic [31:0] write_reg_d, write_data_d;
  logic [7:0]  word_count_d;
  logic        last_word;

  // o_word_count doubles as the write address counter
  assign last_word = (8'(o_word_count + 8'd1) == len_q);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_ok;
  assign csum_ok = (i_rx_data == csum_q);
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_rx_valid && i_rx_data == START_BYTE) state_d = S_LEN;
      S_LEN:   if (i_rx_valid) begin
        if (i_rx_data == 8'd0 || i_rx_data > 8'(DEPTH)) state_d = S_ERROR;
        else                                          state_d = S_DATA;
      end
      S_DATA:  if (i_rx_valid && idx_q == 2'd3) state_d = S_WRITE;
      S_WRITE: begin
        if (!last_word) state_d = S_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
        // a checksum byte landing during the final strobe is resolved at once
        else if (i_rx_valid) state_d = csum_ok ? S_DONE : S_ERROR;
        else                 state_d = S_CHECK;
`else
        else state_d = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (i_rx_valid) state_d = csum_ok ? S_DONE : S_ERROR;
`endif
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    len_d         = len_q;
    idx_d         = idx_q;
    buf_d         = buf_q;
    load_enable_d = 1'b0;
    write_reg_d   = o_write_reg;
    write_data_d  = o_write_data;
    cpu_halt_d    = o_cpu_halt;
    load_done_d   = o_load_done;
    error_d       = o_error;
    word_count_d  = o_word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    case (state_q)
      S_IDLE: if (i_rx_valid && i_rx_data == START_BYTE) begin
        cpu_halt_d   = 1'b1;
        load_done_d  = 1'b0;
        error_d      = 1'b0;
        word_count_d = 8'd0;
        idx_d        = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = 8'd0;
`endif
      end
      S_LEN: if (i_rx_valid) begin
        len_d = i_rx_data;
        idx_d = 2'd0;
      end
      S_DATA: if (i_rx_valid) begin
        buf_d[{idx_q, 3'b000} +: 8] = i_rx_data;
        idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q ^ i_rx_data;
`endif
        if (idx_q == 2'd3) begin
          load_enable_d = 1'b1;
          write_reg_d   = 32'(o_word_count);
          write_data_d  = {i_rx_data, buf_q[23:0]};
        end
      end
      S_WRITE: begin
        word_count_d = 8'(o_word_count + 8'd1);
        // byte arriving during the strobe is byte 0 of the next word
        if (i_rx_valid && !last_word) begin
          buf_d[{idx_q, 3'b000} +: 8] = i_rx_data;
          idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ i_rx_data;
`endif
        end
      end
      S_DONE: begin
        load_done_d = 1'b1;
        cpu_halt_d  = 1'b0;
      end
      S_ERROR: begin
        error_d    = 1'b1;
        cpu_halt_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      len_q         <= 8'd0;
      idx_q         <= 2'd0;
      buf_q         <= 32'd0;
      o_load_enable <= 1'b0;
      o_write_reg   <= 32'd0;
      o_write_data  <= 32'd0;
      o_cpu_halt    <= 1'b0;
      o_load_done   <= 1'b0;
      o_error       <= 1'b0;
      o_word_count  <= 8'd0;
    end else begin
      len_q         <= len_d;
      idx_q         <= idx_d;
      buf_q         <= buf_d;
      o_load_enable <= load_enable_d;
      o_write_reg   <= write_reg_d;
      o_write_data  <= write_data_d;
      o_cpu_halt    <= cpu_halt_d;
      o_load_done   <= load_done_d;
      o_error       <= error_d;
      o_word_count  <= word_count_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) csum_q <= 8'd0;
    else          csum_q <= csum_d;
  end
`endif

endmodule
